// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encodings and default configuration for the pipeline sequencer
package pipe_ctrl_pkg;

  localparam int PIPE_STATE_W = 3;

  // Default configuration values for the sequencer
  localparam int PIPE_RF_RESET_CYCLES_DEF     = 4;
  localparam int PIPE_BOOT_FLUSH_CYCLES_DEF   = 2;
  localparam int PIPE_BRANCH_FLUSH_CYCLES_DEF = 1;
  localparam int PIPE_CNT_W_DEF               = 32;

  typedef enum logic [PIPE_STATE_W-1:0] {
    PIPE_ST_RST_HOLD     = 3'd0,
    PIPE_ST_BOOT_FLUSH   = 3'd1,
    PIPE_ST_RUN          = 3'd2,
    PIPE_ST_BRANCH_FLUSH = 3'd3,
    PIPE_ST_MEM_WAIT     = 3'd4
  } pipe_state_e;

  // True in states where hazard and wait inputs drive the stage controls
  function automatic logic pipe_st_active(input pipe_state_e st);
    return (st == PIPE_ST_RUN) || (st == PIPE_ST_BRANCH_FLUSH) || (st == PIPE_ST_MEM_WAIT);
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// rtl/pipe_perf_cnt.sv - enable-driven wrapping performance counter
module pipe_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // Count enabled cycles; the counter wraps naturally at 2^W
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline sequencer merging hazards and memory waits into stage stall/clear controls
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RF_RESET_CYCLES     = PIPE_RF_RESET_CYCLES_DEF,
  parameter int BOOT_FLUSH_CYCLES   = PIPE_BOOT_FLUSH_CYCLES_DEF,
  parameter int BRANCH_FLUSH_CYCLES = PIPE_BRANCH_FLUSH_CYCLES_DEF,
  parameter int CNT_W               = PIPE_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             i_mem_hazard,
  input  logic             i_branch_taken,
  input  logic             i_imem_ready,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ready,
  output logic             o_rf_reset,
  output logic             o_if_stall,
  output logic             o_id_stall,
  output logic             o_id_clr,
  output logic             o_ex_stall,
  output logic             o_ex_clr,
  output logic             o_me_stall,
  output logic             o_wb_clr,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  // Down-counter reload values; the counter expires at zero, so load N-1
  localparam logic [3:0] RF_INIT   = 4'(RF_RESET_CYCLES - 1);
  localparam logic [3:0] BOOT_INIT = 4'(BOOT_FLUSH_CYCLES - 1);
  localparam logic [1:0] BR_INIT   = 2'(BRANCH_FLUSH_CYCLES - 1);

  pipe_state_e state;
  pipe_state_e state_nxt;
  logic [3:0]  seq_cnt;
  logic [3:0]  seq_cnt_nxt;
  logic [1:0]  br_cnt;
  logic [1:0]  br_cnt_nxt;
  logic        dmem_wait;
  logic        flush_inc;
  logic        stall_inc;

  assign dmem_wait = i_dmem_req & ~i_dmem_ready;

  // Mealy control decode and next-state selection from state and live hazard inputs
  always_comb begin
    state_nxt   = state;
    seq_cnt_nxt = seq_cnt;
    br_cnt_nxt  = br_cnt;
    flush_inc   = 1'b0;
    o_rf_reset  = 1'b1;
    o_if_stall  = 1'b0;
    o_id_stall  = 1'b0;
    o_id_clr    = 1'b0;
    o_ex_stall  = 1'b0;
    o_ex_clr    = 1'b0;
    o_me_stall  = 1'b0;
    o_wb_clr    = 1'b0;

    case (state)
      PIPE_ST_RST_HOLD: begin
        o_rf_reset = 1'b0;
        o_id_clr   = 1'b1;
        o_ex_clr   = 1'b1;
        o_wb_clr   = 1'b1;
        if (seq_cnt == 4'd0) begin
          state_nxt   = PIPE_ST_BOOT_FLUSH;
          seq_cnt_nxt = BOOT_INIT;
        end else begin
          seq_cnt_nxt = seq_cnt - 4'd1;
        end
      end

      PIPE_ST_BOOT_FLUSH: begin
        o_id_clr = 1'b1;
        o_ex_clr = 1'b1;
        o_wb_clr = 1'b1;
        if (seq_cnt == 4'd0) begin
          state_nxt = PIPE_ST_RUN;
        end else begin
          seq_cnt_nxt = seq_cnt - 4'd1;
        end
      end

      default: begin
        // A branch held in EX across a memory wait is seen again on the
        // ready cycle; it was already counted when the wait began.
        flush_inc = i_branch_taken && (state != PIPE_ST_MEM_WAIT);
        if (dmem_wait) begin
          // Freeze everything, including any remaining branch flush count
          o_if_stall = 1'b1;
          o_id_stall = 1'b1;
          o_ex_stall = 1'b1;
          o_me_stall = 1'b1;
          o_wb_clr   = 1'b1;
          state_nxt  = PIPE_ST_MEM_WAIT;
        end else if (i_branch_taken) begin
          // Branch outranks the load-use hazard: that instruction is wrong-path
          o_id_clr   = 1'b1;
          o_ex_clr   = 1'b1;
          br_cnt_nxt = BR_INIT;
          state_nxt  = (BR_INIT != 2'd0) ? PIPE_ST_BRANCH_FLUSH : PIPE_ST_RUN;
        end else if (br_cnt != 2'd0) begin
          o_id_clr   = 1'b1;
          o_ex_clr   = 1'b1;
          br_cnt_nxt = br_cnt - 2'd1;
          state_nxt  = (br_cnt == 2'd1) ? PIPE_ST_RUN : PIPE_ST_BRANCH_FLUSH;
        end else if (i_mem_hazard) begin
          o_if_stall = 1'b1;
          o_id_stall = 1'b1;
          o_ex_clr   = 1'b1;
          state_nxt  = PIPE_ST_RUN;
        end else if (!i_imem_ready) begin
          o_if_stall = 1'b1;
          o_id_clr   = 1'b1;
          state_nxt  = PIPE_ST_RUN;
        end else begin
          state_nxt = PIPE_ST_RUN;
        end
      end
    endcase
  end

  // Sequencer state, boot down-counter and branch flush remainder
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= PIPE_ST_RST_HOLD;
      seq_cnt <= RF_INIT;
      br_cnt  <= 2'd0;
    end else begin
      state   <= state_nxt;
      seq_cnt <= seq_cnt_nxt;
      br_cnt  <= br_cnt_nxt;
    end
  end

  assign o_busy    = (state != PIPE_ST_RUN);
  assign stall_inc = o_if_stall & pipe_st_active(state);

  pipe_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .aresetn (aresetn),
    .en      (stall_inc),
    .cnt     (o_stall_cnt)
  );

  pipe_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .aresetn (aresetn),
    .en      (flush_inc),
    .cnt     (o_flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for the pipeline sequencer
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        i_mem_hazard;
  logic        i_branch_taken;
  logic        i_imem_ready;
  logic        i_dmem_req;
  logic        i_dmem_ready;
  logic        o_rf_reset;
  logic        o_if_stall;
  logic        o_id_stall;
  logic        o_id_clr;
  logic        o_ex_stall;
  logic        o_ex_clr;
  logic        o_me_stall;
  logic        o_wb_clr;
  logic        o_busy;
  logic [31:0] o_stall_cnt;
  logic [31:0] o_flush_cnt;
  logic [6:0]  ctl;

  int n_cmp = 0;
  int n_bad = 0;

  // {if_stall, id_stall, id_clr, ex_stall, ex_clr, me_stall, wb_clr}
  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_HAZ    = 7'b1100100;
  localparam logic [6:0] C_DWAIT  = 7'b1101011;
  localparam logic [6:0] C_BRANCH = 7'b0010100;
  localparam logic [6:0] C_IMEM   = 7'b1010000;
  localparam logic [6:0] C_BOOT   = 7'b0010101;

  assign ctl = {o_if_stall, o_id_stall, o_id_clr, o_ex_stall, o_ex_clr, o_me_stall, o_wb_clr};

  pipe_ctrl #(
    .RF_RESET_CYCLES     (4),
    .BOOT_FLUSH_CYCLES   (2),
    .BRANCH_FLUSH_CYCLES (2),
    .CNT_W               (32)
  ) dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .i_mem_hazard   (i_mem_hazard),
    .i_branch_taken (i_branch_taken),
    .i_imem_ready   (i_imem_ready),
    .i_dmem_req     (i_dmem_req),
    .i_dmem_ready   (i_dmem_ready),
    .o_rf_reset     (o_rf_reset),
    .o_if_stall     (o_if_stall),
    .o_id_stall     (o_id_stall),
    .o_id_clr       (o_id_clr),
    .o_ex_stall     (o_ex_stall),
    .o_ex_clr       (o_ex_clr),
    .o_me_stall     (o_me_stall),
    .o_wb_clr       (o_wb_clr),
    .o_busy         (o_busy),
    .o_stall_cnt    (o_stall_cnt),
    .o_flush_cnt    (o_flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; Mealy outputs are sampled 1ns later
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    int rf_low;
    int clr_hi;
    int busy_fall;

    aresetn        = 1'b0;
    i_mem_hazard   = 1'b0;
    i_branch_taken = 1'b0;
    i_imem_ready   = 1'b1;
    i_dmem_req     = 1'b0;
    i_dmem_ready   = 1'b1;
    repeat (2) next_cycle();
    #1;
    check("rst_ctl",    32'(ctl), 32'(C_BOOT));
    check("rst_rf",     32'(o_rf_reset), 32'd0);
    check("rst_busy",   32'(o_busy), 32'd1);
    check("rst_stalls", o_stall_cnt, 32'd0);
    check("rst_flush",  o_flush_cnt, 32'd0);

    // Boot sequence: count cycles of rf_reset low, clears high, first busy-low cycle
    next_cycle();
    aresetn   = 1'b1;
    rf_low    = 0;
    clr_hi    = 0;
    busy_fall = 0;
    for (int k = 1; k <= 10; k++) begin
      #1;
      if (!o_rf_reset) rf_low++;
      if (ctl == C_BOOT) clr_hi++;
      if (!o_busy && busy_fall == 0) busy_fall = k;
      next_cycle();
    end
    check("boot_rf_low",    32'(rf_low), 32'd4);
    check("boot_clr_hi",    32'(clr_hi), 32'd6);
    check("boot_busy_fall", 32'(busy_fall), 32'd7);
    #1;
    check("boot_idle_ctl",  32'(ctl), 32'(C_NONE));
    check("boot_stall_cnt", o_stall_cnt, 32'd0);

    // Single-cycle load-use hazard
    i_mem_hazard = 1'b1;
    #1;
    check("haz_ctl", 32'(ctl), 32'(C_HAZ));
    next_cycle();
    i_mem_hazard = 1'b0;
    #1;
    check("haz_after_ctl", 32'(ctl), 32'(C_NONE));
    check("haz_stall_cnt", o_stall_cnt, 32'd1);

    // Three-cycle data memory wait
    next_cycle();
    i_dmem_req   = 1'b1;
    i_dmem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("dw_ctl", 32'(ctl), 32'(C_DWAIT));
      next_cycle();
    end
    i_dmem_ready = 1'b1;
    #1;
    check("dw_ready_ctl",  32'(ctl), 32'(C_NONE));
    check("dw_ready_busy", 32'(o_busy), 32'd1);
    next_cycle();
    i_dmem_req = 1'b0;
    #1;
    check("dw_done_busy",  32'(o_busy), 32'd0);
    check("dw_stall_cnt",  o_stall_cnt, 32'd4);

    // Taken branch with a two-cycle flush
    next_cycle();
    i_branch_taken = 1'b1;
    #1;
    check("br_ctl0", 32'(ctl), 32'(C_BRANCH));
    next_cycle();
    i_branch_taken = 1'b0;
    #1;
    check("br_ctl1",  32'(ctl), 32'(C_BRANCH));
    check("br_busy1", 32'(o_busy), 32'd1);
    next_cycle();
    #1;
    check("br_ctl2",   32'(ctl), 32'(C_NONE));
    check("br_flush",  o_flush_cnt, 32'd1);

    // Branch and hazard together: branch wins, no stall
    next_cycle();
    i_branch_taken = 1'b1;
    i_mem_hazard   = 1'b1;
    #1;
    check("brhz_ctl0", 32'(ctl), 32'(C_BRANCH));
    next_cycle();
    i_branch_taken = 1'b0;
    i_mem_hazard   = 1'b0;
    #1;
    check("brhz_ctl1", 32'(ctl), 32'(C_BRANCH));
    next_cycle();
    #1;
    check("brhz_flush", o_flush_cnt, 32'd2);
    check("brhz_stall", o_stall_cnt, 32'd4);

    // Branch held across a two-cycle memory wait
    next_cycle();
    i_branch_taken = 1'b1;
    i_dmem_req     = 1'b1;
    i_dmem_ready   = 1'b0;
    #1;
    check("brdw_ctl0", 32'(ctl), 32'(C_DWAIT));
    next_cycle();
    #1;
    check("brdw_ctl1", 32'(ctl), 32'(C_DWAIT));
    next_cycle();
    i_dmem_ready = 1'b1;
    #1;
    check("brdw_ctl2",   32'(ctl), 32'(C_BRANCH));
    check("brdw_flush2", o_flush_cnt, 32'd3);
    next_cycle();
    i_branch_taken = 1'b0;
    i_dmem_req     = 1'b0;
    #1;
    check("brdw_ctl3", 32'(ctl), 32'(C_BRANCH));
    next_cycle();
    #1;
    check("brdw_ctl4",  32'(ctl), 32'(C_NONE));
    check("brdw_flush", o_flush_cnt, 32'd3);
    check("brdw_stall", o_stall_cnt, 32'd6);

    // Instruction fetch not ready
    next_cycle();
    i_imem_ready = 1'b0;
    #1;
    check("imem_ctl", 32'(ctl), 32'(C_IMEM));
    next_cycle();
    i_imem_ready = 1'b1;
    #1;
    check("imem_stall", o_stall_cnt, 32'd7);

    // Asynchronous reset in the middle of a memory wait
    next_cycle();
    i_dmem_req   = 1'b1;
    i_dmem_ready = 1'b0;
    next_cycle();
    #1;
    aresetn = 1'b0;
    #1;
    check("arst_busy",  32'(o_busy), 32'd1);
    check("arst_rf",    32'(o_rf_reset), 32'd0);
    check("arst_ctl",   32'(ctl), 32'(C_BOOT));
    check("arst_stall", o_stall_cnt, 32'd0);
    check("arst_flush", o_flush_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage core (IF/ID/EX/ME/WB).
- Merges hazard and wait sources into per-stage stall/clear controls: ID load-use hazard, EX branch redirect, instruction-memory wait, data-memory wait.
- Sequences post-reset boot: holds the register-file reset, then flushes every stage.
- Maintains stall/flush performance counters.

Parameters:
RF_RESET_CYCLES, 4, cycles o_rf_reset stays low after aresetn deasserts (1..15)
BOOT_FLUSH_CYCLES, 2, cycles all stage clears stay asserted after RF reset release (1..15)
BRANCH_FLUSH_CYCLES, 1, cycles ID/EX clears stay asserted per taken branch (1..3)
CNT_W, 32, perf counter width

Ports:
clk  in  1  core clock
aresetn  in  1  asynchronous active-low reset
i_mem_hazard  in  1  ID load-use hazard (combinational from ID stage)
i_branch_taken  in  1  EX resolved taken branch/jump this cycle
i_imem_ready  in  1  instruction fetch data valid
i_dmem_req  in  1  ME stage holds a load/store
i_dmem_ready  in  1  data memory completes ME access this cycle
o_rf_reset  out  1  active-low register-file reset
o_if_stall  out  1  hold PC/fetch
o_id_stall  out  1  hold ID pipeline register
o_id_clr  out  1  synchronous clear of ID register
o_ex_stall  out  1  hold EX register
o_ex_clr  out  1  clear EX register (bubble)
o_me_stall  out  1  hold ME register
o_wb_clr  out  1  clear WB register
o_busy  out  1  high in any state other than RUN
o_stall_cnt  out  CNT_W  cycles with o_if_stall high
o_flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- Async reset (aresetn=0):
  - state=RST_HOLD, counters=0.
  - o_rf_reset=0; all clears=1; all stalls=0; o_busy=1.
- Outputs are Mealy: combinational from state and current inputs. A hazard seen in cycle N therefore acts at edge N+1.
- States: RST_HOLD, BOOT_FLUSH, RUN, BRANCH_FLUSH, MEM_WAIT.
- RST_HOLD:
  - o_rf_reset=0, all clears=1.
  - Down-counter loaded with RF_RESET_CYCLES-1; move to BOOT_FLUSH when it reaches 0.
- BOOT_FLUSH:
  - o_rf_reset=1, all clears=1.
  - Run BOOT_FLUSH_CYCLES cycles, then RUN.
  - Hazard/wait inputs are ignored in RST_HOLD and BOOT_FLUSH.
- RUN/MEM_WAIT/BRANCH_FLUSH use one priority chain (highest first):
  1. Data-memory wait, i_dmem_req & !i_dmem_ready:
     - o_if_stall=o_id_stall=o_ex_stall=o_me_stall=1, o_wb_clr=1.
     - Next state MEM_WAIT; a pending branch flush count is frozen, not lost.
  2. i_branch_taken:
     - o_id_clr=o_ex_clr=1, no stalls.
     - If BRANCH_FLUSH_CYCLES>1, next state BRANCH_FLUSH with remaining count; otherwise stay RUN.
     - o_flush_cnt increments.
  3. Remaining BRANCH_FLUSH count: o_id_clr=o_ex_clr=1; decrement; return to RUN at 0.
  4. i_mem_hazard:
     - o_if_stall=o_id_stall=1, o_ex_clr=1 (one bubble).
     - Stays RUN; the hazard self-clears once the load reaches ME.
  5. !i_imem_ready: o_if_stall=1, o_id_clr=1 (bubble into ID).
  6. Otherwise all controls 0.
- MEM_WAIT:
  - Hold until i_dmem_ready=1.
  - On that cycle, controls follow the chain without rule 1.
  - Next state is BRANCH_FLUSH if a count is frozen, else RUN.
- Simultaneous branch + mem_hazard: branch wins. The hazard-causing instruction is wrong-path and is cleared.
- Simultaneous branch + dmem wait: stall wins. The branch event is counted once, and the flush is applied on the first non-waiting cycle. EX is held, so i_branch_taken remains asserted.
- A branch that stays asserted across consecutive MEM_WAIT cycles counts once. The count is qualified by "not in MEM_WAIT last cycle or first ready cycle".
- Counters:
  - Wrap modulo 2^CNT_W.
  - o_stall_cnt counts every cycle with o_if_stall=1 while state is not RST_HOLD or BOOT_FLUSH.
- aresetn asserted mid-MEM_WAIT or mid-flush: immediate return to RST_HOLD, counters cleared.

Decomposition:
- Shared package / config.vh: PIPE_STATE_W, state encodings PIPE_ST_*, default parameter values.
- Sub-module: pipe_perf_cnt (enable-driven wrapping counter), instantiated twice.

Test Plan:
- Reset release with RF_RESET_CYCLES=4, BOOT_FLUSH_CYCLES=2 -> o_rf_reset low exactly 4 cycles; clears high 6 cycles total; o_busy falls on cycle 7.
- i_mem_hazard pulse 1 cycle in RUN -> same cycle o_if_stall=o_id_stall=o_ex_clr=1; next cycle all 0; o_stall_cnt=1.
- i_dmem_req=1 with i_dmem_ready low 3 cycles -> IF/ID/EX/ME stalls and o_wb_clr high 3 cycles, then release; o_stall_cnt=3.
- i_branch_taken with BRANCH_FLUSH_CYCLES=2 -> o_id_clr/o_ex_clr high 2 consecutive cycles; o_flush_cnt=1.
- i_branch_taken and i_mem_hazard same cycle -> only clears asserted, no stalls.
- Branch held during a 2-cycle dmem wait -> stalls 2 cycles, then flush; o_flush_cnt increments by exactly 1.
